weight_write: RTL and testbench

Fills the eight weight BRAM banks from a 256-bit DMA stream, one ping-pong half at a time, for the weight reader. Each load writes one half: bank base 0 (half 0) or 512 (half 1). Per-half ownership flags provide backpressure, so a half is never overwritten before the reader releases it. Four loads make up one layer transfer.

---
 rtl/weight_write_if.sv | 27 ++
 rtl/weight_write.sv | 165 ++++++++++++++++
 tb/tb_weight_write.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_write_if.sv
// ---------------------------------------------------------------------------
// weight_write_if
//   256-bit weight stream carried from the DMA engine into weight_write.
//
//   s_data   stream beat
//   s_valid  beat valid (driven by the master)
//   s_ready  beat accepted when s_valid && s_ready (driven by the slave)
// ---------------------------------------------------------------------------
interface weight_write_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/weight_write.sv
// ---------------------------------------------------------------------------
// weight_write
//   Fills the eight weight BRAM banks from a 256-bit DMA stream, one
//   ping-pong half per load. Half 0 starts at address 0, half 1 at HALF_BASE.
//   Four loads form one layer transfer. A half is only written when its
//   half_full flag is clear; the weight reader frees halves with release_req.
//
//   clk          clock
//   rst          synchronous, active-high reset
//   start        one-cycle pulse starting a layer transfer (IDLE only)
//   layer        layer id (1..4), sampled with start
//   release_req  reader's read_done pulse; frees the oldest full half
//                (named release_req because "release" is a reserved word)
//   s            stream slave (s_data, s_valid, s_ready)
//   wr_en        one-hot bank write enable
//   addr_wr      BRAM write address
//   dout         BRAM write data, shared by all banks
//   half_full    bit h set: half h holds unread weights
//   load_done    one-cycle pulse when a half has been completely written
//   xfer_done    one-cycle pulse when the 4th load of a transfer completes
// ---------------------------------------------------------------------------
module weight_write #(
    parameter int DATA_WIDTH = 256,
    parameter int HALF_BASE  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            layer,
    input  logic                  release_req,
    weight_write_if.slave         s,
    output logic [7:0]            wr_en,
    output logic [11:0]           addr_wr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            half_full,
    output logic                  load_done,
    output logic                  xfer_done
);

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        FILL,
        WAIT
    } state_t;

    state_t     state_c;
    logic [2:0] layer_reg;
    logic [8:0] wpb_last;   // words per bank per load, minus one
    logic [2:0] cnt_bank;
    logic [8:0] cnt_word;
    logic [1:0] cnt_load;
    logic       wp;         // half currently being written
    logic       rp;         // oldest half the reader has not released

    logic       beat;
    logic       last_beat;
    logic       rel_eff;
    logic [1:0] half_full_nxt;
    logic [11:0] base_addr;

    assign s.s_ready = (state_c == FILL);

    assign beat      = s.s_valid && (state_c == FILL);
    assign last_beat = beat && (cnt_bank == 3'd7) && (cnt_word == wpb_last);

    // A release with no full half at rp is dropped and leaves rp alone.
    assign rel_eff   = release_req && half_full[rp];

    assign base_addr = wp ? 12'(HALF_BASE) : 12'd0;

    // Clear first, then set: if both ever hit the same half, the set wins.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        half_full_nxt = half_full;
        if (rel_eff) begin
            half_full_nxt[rp] = 1'b0;
        end
        if (last_beat) begin
            half_full_nxt[wp] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_c   <= IDLE;
            layer_reg <= '0;
            wpb_last  <= 9'd15;
            cnt_bank  <= '0;
            cnt_word  <= '0;
            cnt_load  <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            half_full <= '0;
            wr_en     <= '0;
            addr_wr   <= '0;
            dout      <= '0;
            load_done <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            wr_en     <= '0;
            load_done <= 1'b0;
            xfer_done <= 1'b0;
            half_full <= half_full_nxt;

            if (rel_eff) begin
                rp <= ~rp;
            end

            // Beat i of a load lands in bank i[2:0] at word i>>3 of the half.
            if (beat) begin
                wr_en    <= 8'd1 << cnt_bank;
                addr_wr  <= base_addr + {3'b000, cnt_word};
                dout     <= s.s_data;
                cnt_bank <= cnt_bank + 3'd1;
                if (cnt_bank == 3'd7) begin
                    cnt_word <= (cnt_word == wpb_last) ? 9'd0 : cnt_word + 9'd1;
                end
            end

            unique case (state_c)
                IDLE: begin
                    // Pointers are cleared on start rather than on entry to
                    // IDLE, so the reader can still drain after xfer_done.
                    if (start) begin
                        layer_reg <= layer;
                        wp        <= 1'b0;
                        rp        <= 1'b0;
                        cnt_bank  <= '0;
                        cnt_word  <= '0;
                        cnt_load  <= '0;
                        state_c   <= CONFIG;
                    end
                end
                CONFIG: begin
                    wpb_last <= (layer_reg inside {3'd2, 3'd3, 3'd4}) ? 9'd511 : 9'd15;
                    // Half 0 may still be held by the reader from the last
                    // transfer; park in WAIT instead of overwriting it.
                    state_c  <= half_full[wp] ? WAIT : FILL;
                end
                FILL: begin
                    if (last_beat) begin
                        load_done <= 1'b1;
                        wp        <= ~wp;
                        cnt_load  <= cnt_load + 2'd1;
                        if (cnt_load == 2'd3) begin
                            xfer_done <= 1'b1;
                            state_c   <= IDLE;
                        end else begin
                            state_c   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!half_full[wp]) begin
                        state_c <= FILL;
                    end
                end
                default: state_c <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_write.sv
// ---------------------------------------------------------------------------
// tb_weight_write
//   Directed sequence with random data and random valid gaps. The reference
//   model tracks each transfer as a flat beat count and derives bank, address,
//   half and pulse expectations arithmetically from it.
// ---------------------------------------------------------------------------
module tb_weight_write;

    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    layer = 3'd0;
    logic          release_req = 1'b0;
    logic [7:0]    wr_en;
    logic [11:0]   addr_wr;
    logic [DW-1:0] dout;
    logic [1:0]    half_full;
    logic          load_done;
    logic          xfer_done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       g        = 0;    // beats accepted in the current transfer
    int       wpb_m    = 16;   // words per bank per load
    logic [1:0] hf_m   = 2'b00;
    logic     rp_m     = 1'b0;
    logic     active_m = 1'b0;
    logic     last_ld  = 1'b0; // load_done expected in the previous cycle

    weight_write_if #(.DATA_WIDTH(DW)) sif ();

    weight_write #(
        .DATA_WIDTH(DW),
        .HALF_BASE (512)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .layer      (layer),
        .release_req(release_req),
        .s          (sif.slave),
        .wr_en      (wr_en),
        .addr_wr    (addr_wr),
        .dout       (dout),
        .half_full  (half_full),
        .load_done  (load_done),
        .xfer_done  (xfer_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict, step past the edge, compare.
    task automatic cycle(input logic v, input logic rel, input logic st, input logic [2:0] ly);
        logic          acc;
        logic          start_ok;
        logic          exp_ld;
        logic          exp_xd;
        logic [7:0]    exp_we;
        logic [11:0]   exp_addr;
        logic [DW-1:0] d;
        logic [1:0]    hf_next;
        int            beats;
        int            ld;
        int            bi;

        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        sif.s_valid = v;
        sif.s_data  = d;
        release_req = rel;
        start       = st;
        layer       = ly;

        acc      = v && sif.s_ready;
        start_ok = st && !active_m;
        exp_ld   = 1'b0;
        exp_xd   = 1'b0;
        exp_we   = 8'd0;
        exp_addr = 12'd0;
        hf_next  = hf_m;

        if (rel && hf_m[rp_m]) begin
            hf_next[rp_m] = 1'b0;
            rp_m = ~rp_m;
        end
        if (acc) begin
            beats    = 8 * wpb_m;
            ld       = g / beats;
            bi       = g % beats;
            exp_we   = 8'd1 << (bi % 8);
            exp_addr = 12'((ld % 2) * 512 + bi / 8);
            if (bi == beats - 1) begin
                exp_ld = 1'b1;
                hf_next[ld % 2] = 1'b1;
                if (ld == 3) begin
                    exp_xd   = 1'b1;
                    active_m = 1'b0;
                end
            end
            g++;
        end
        if (start_ok) begin
            active_m = 1'b1;
            g        = 0;
            rp_m     = 1'b0;
            wpb_m    = (ly >= 3'd2 && ly <= 3'd4) ? 512 : 16;
        end

        @(posedge clk);
        #1;
        if (acc) begin
            check("wr_en", DW'(wr_en), DW'(exp_we));
            check("addr_wr", DW'(addr_wr), DW'(exp_addr));
            check("dout", dout, d);
        end else begin
            check("wr_idle", DW'(wr_en), DW'(0));
        end
        check("load_done", DW'(load_done), DW'(exp_ld));
        check("xfer_done", DW'(xfer_done), DW'(exp_xd));
        check("half_full", DW'(half_full), DW'(hf_next));
        hf_m    = hf_next;
        last_ld = exp_ld;
    endtask

    // Stream beats until the transfer beat count reaches target or the
    // transfer ends, optionally releasing each half right after load_done.
    task automatic run(input int target, input int gap_pct, input logic rel_after, input int max_cycles);
        int   n;
        logic v;
        n = 0;
        while (active_m && g < target && n < max_cycles) begin
            v = ($urandom_range(99) >= gap_pct);
            cycle(v, rel_after && last_ld, 1'b0, 3'd0);
            n++;
        end
        check("run_progress", DW'(g >= target || !active_m), DW'(1));
    endtask

    task automatic begin_xfer(input logic [2:0] ly);
        cycle(1'b0, 1'b0, 1'b1, ly);
        check("config_ready", DW'(sif.s_ready), DW'(0));
        cycle(1'b0, 1'b0, 1'b0, 3'd0);
        check("fill_ready", DW'(sif.s_ready), DW'(1));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sif.s_valid = 1'b1;
        start       = 1'b0;
        release_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wr_en", DW'(wr_en), DW'(0));
        check("rst_addr", DW'(addr_wr), DW'(0));
        check("rst_dout", dout, DW'(0));
        check("rst_half_full", DW'(half_full), DW'(0));
        check("rst_load_done", DW'(load_done), DW'(0));
        check("rst_xfer_done", DW'(xfer_done), DW'(0));
        check("rst_s_ready", DW'(sif.s_ready), DW'(0));
        rst         = 1'b0;
        sif.s_valid = 1'b0;
        hf_m        = 2'b00;
        rp_m        = 1'b0;
        active_m    = 1'b0;
        g           = 0;
        last_ld     = 1'b0;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        @(posedge clk);
        do_reset();

        // Layer 1, continuous valid, reader releases after every load_done.
        begin_xfer(3'd1);
        run(1 << 30, 0, 1'b1, 2000);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);   // reader drains the last half in IDLE
        check("idle_ready", DW'(sif.s_ready), DW'(0));
        check("drained", DW'(half_full), DW'(0));

        // Ignored release with nothing full, then release colliding with the
        // load_done of the other half.
        begin_xfer(3'd1);
        cycle(1'b1, 1'b1, 1'b0, 3'd0);
        run(128, 0, 1'b0, 500);
        while (active_m && g < 256) begin
            cycle(1'b1, (g == 255) && sif.s_ready, 1'b0, 3'd0);
        end
        check("same_cycle_hf", DW'(half_full), DW'(2'b10));
        run(1 << 30, 0, 1'b1, 2000);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);

        // Layer 2 without release: both halves fill and the stream stalls.
        // A start during FILL asking for layer 1 must not change WPB.
        begin_xfer(3'd2);
        run(1000, 0, 1'b0, 1200);
        cycle(1'b1, 1'b0, 1'b1, 3'd1);
        run(8192, 0, 1'b0, 9000);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0);
            check("stall_ready", DW'(sif.s_ready), DW'(0));
        end
        check("both_full", DW'(half_full), DW'(2'b11));
        cycle(1'b1, 1'b1, 1'b0, 3'd0);
        run(8193, 0, 1'b0, 50);
        check("resume_bank", DW'(wr_en), DW'(8'h01));
        check("resume_addr", DW'(addr_wr), DW'(0));
        do_reset();

        // Layer 3 with 50% valid gaps over one full load.
        begin_xfer(3'd3);
        run(4096, 50, 1'b0, 20000);
        check("beat4095_bank", DW'(wr_en), DW'(8'h80));
        check("beat4095_addr", DW'(addr_wr), DW'(511));
        check("beat4095_done", DW'(load_done), DW'(1));
        do_reset();

        // Layer 4 aborted by reset at beat 300, then a fresh layer-1 transfer.
        begin_xfer(3'd4);
        run(300, 0, 1'b0, 400);
        do_reset();
        begin_xfer(3'd1);
        run(1, 0, 1'b0, 10);
        check("restart_bank", DW'(wr_en), DW'(8'h01));
        check("restart_addr", DW'(addr_wr), DW'(0));
        run(1 << 30, 0, 1'b1, 2000);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);
        check("final_idle", DW'(half_full), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
